// File: rtl/cpu_memory_pkg.sv
// Shared encodings for the Chip-8 memory with fill/copy engine.
// Holds op codes, engine states and default widths.
package cpu_memory_pkg;

  localparam int DATA_W_DEF      = 8;
  localparam int ADDR_W_DEF      = 12;
  localparam int PROTECT_TOP_DEF = 512;

  typedef enum logic {
    OP_FILL = 1'b0,
    OP_COPY = 1'b1
  } op_e;

  typedef enum logic [2:0] {
    IDLE,
    FILL,
    COPY_RD,
    COPY_WR,
    DONE
  } eng_state_e;

endpackage

// File: rtl/dp_ram.sv
// Plain dual-port storage: A = read/write, B = read-only, read-first.
// Ports: clk, rst (clears output regs only), a_re/a_we/a_addr/a_wdata/a_rdata, b_addr/b_rdata.
module dp_ram #(
  parameter int    DATA_W    = 8,
  parameter int    ADDR_W    = 12,
  parameter string INIT_FILE = ""
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              a_re,
  input  logic              a_we,
  input  logic [ADDR_W-1:0] a_addr,
  input  logic [DATA_W-1:0] a_wdata,
  output logic [DATA_W-1:0] a_rdata,
  input  logic [ADDR_W-1:0] b_addr,
  output logic [DATA_W-1:0] b_rdata
);

  localparam int DEPTH = 1 << ADDR_W;

  logic [DATA_W-1:0] mem [DEPTH];
  logic [DATA_W-1:0] a_rdata_d, a_rdata_q;
  logic [DATA_W-1:0] b_rdata_d, b_rdata_q;

  always_ff @(posedge clk) begin
    if (a_we) mem[a_addr] <= a_wdata;
  end

  always_comb begin
    a_rdata_d = a_re ? mem[a_addr] : a_rdata_q;
    b_rdata_d = mem[b_addr];
  end

  // Contents survive reset; only the read registers clear.
  always_ff @(posedge clk) begin
    if (rst) begin
      a_rdata_q <= '0;
      b_rdata_q <= '0;
    end else begin
      a_rdata_q <= a_rdata_d;
      b_rdata_q <= b_rdata_d;
    end
  end

  assign a_rdata = a_rdata_q;
  assign b_rdata = b_rdata_q;

endmodule

// File: rtl/cpu_memory_dma.sv
// CPU memory with write-protect and a low-priority fill/copy engine on port A.
// Ports: CPU port A (a_*), video port B (b_*), engine command (cmd_*), busy/done.
module cpu_memory_dma
  import cpu_memory_pkg::*;
#(
  parameter int    DATA_W      = DATA_W_DEF,
  parameter int    ADDR_W      = ADDR_W_DEF,
  parameter int    PROTECT_TOP = PROTECT_TOP_DEF,
  parameter string INIT_FILE   = ""
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              a_en,
  input  logic              a_write,
  input  logic [ADDR_W-1:0] a_addr,
  input  logic [DATA_W-1:0] a_in,
  output logic [DATA_W-1:0] a_out,
  output logic              a_wp_err,
  input  logic [ADDR_W-1:0] b_addr,
  output logic [DATA_W-1:0] b_out,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic              cmd_op,
  input  logic [ADDR_W-1:0] cmd_src,
  input  logic [ADDR_W-1:0] cmd_dst,
  input  logic [ADDR_W:0]   cmd_len,
  input  logic [DATA_W-1:0] cmd_data,
  output logic              busy,
  output logic              done
);

  localparam logic [ADDR_W:0] PROT_LIM = (ADDR_W+1)'(PROTECT_TOP);
  localparam logic [ADDR_W:0] LEN_ONE  = (ADDR_W+1)'(1);
  localparam logic [ADDR_W-1:0] A_ONE  = ADDR_W'(1);

  eng_state_e        state_d, state_q;
  logic [ADDR_W-1:0] src_d, src_q;
  logic [ADDR_W-1:0] dst_d, dst_q;
  logic [ADDR_W:0]   len_d, len_q;
  logic [DATA_W-1:0] data_d, data_q;
  logic [DATA_W-1:0] hold_d, hold_q;
  logic              eng_rd_d, eng_rd_q;
  logic              cpu_rd_d, cpu_rd_q;
  logic [DATA_W-1:0] a_last_d, a_last_q;
  logic              wp_err_d, wp_err_q;

  logic              ram_re, ram_we;
  logic [ADDR_W-1:0] ram_addr;
  logic [DATA_W-1:0] ram_wdata, ram_rdata;
  logic [DATA_W-1:0] copy_data;
  logic              a_prot;

  assign a_prot = {1'b0, a_addr} < PROT_LIM;

  // Source byte arrives one cycle after COPY_RD; later cycles use the copy
  // held back from that cycle, since a CPU read may overwrite ram_rdata.
  assign copy_data = eng_rd_q ? ram_rdata : hold_q;

  // CPU sees RAM data only after its own read; otherwise a_out holds.
  assign a_out = cpu_rd_q ? ram_rdata : a_last_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= IDLE;
      src_q    <= '0;
      dst_q    <= '0;
      len_q    <= '0;
      data_q   <= '0;
      hold_q   <= '0;
      eng_rd_q <= 1'b0;
      cpu_rd_q <= 1'b0;
      a_last_q <= '0;
      wp_err_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      src_q    <= src_d;
      dst_q    <= dst_d;
      len_q    <= len_d;
      data_q   <= data_d;
      hold_q   <= hold_d;
      eng_rd_q <= eng_rd_d;
      cpu_rd_q <= cpu_rd_d;
      a_last_q <= a_last_d;
      wp_err_q <= wp_err_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    src_d    = src_q;
    dst_d    = dst_q;
    len_d    = len_q;
    data_d   = data_q;
    hold_d   = eng_rd_q ? ram_rdata : hold_q;
    eng_rd_d = (state_q == COPY_RD) && !a_en;
    cpu_rd_d = a_en;
    a_last_d = a_out;
    wp_err_d = a_en && a_write && a_prot;
    unique case (state_q)
      IDLE: begin
        if (cmd_valid) begin
          src_d  = cmd_src;
          dst_d  = cmd_dst;
          len_d  = cmd_len;
          data_d = cmd_data;
          if (cmd_len == '0)          state_d = DONE;
          else if (cmd_op == OP_COPY) state_d = COPY_RD;
          else                        state_d = FILL;
        end
      end
      FILL: begin
        if (!a_en) begin
          dst_d = dst_q + A_ONE;
          len_d = len_q - LEN_ONE;
          if (len_q == LEN_ONE) state_d = DONE;
        end
      end
      COPY_RD: begin
        if (!a_en) begin
          src_d   = src_q + A_ONE;
          state_d = COPY_WR;
        end
      end
      COPY_WR: begin
        if (!a_en) begin
          dst_d   = dst_q + A_ONE;
          len_d   = len_q - LEN_ONE;
          state_d = (len_q == LEN_ONE) ? DONE : COPY_RD;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Port A arbitration: CPU wins; engine writes bypass protection.
  always_comb begin
    cmd_ready = (state_q == IDLE);
    busy      = (state_q != IDLE);
    done      = (state_q == DONE);
    ram_re    = 1'b0;
    ram_we    = 1'b0;
    ram_addr  = dst_q;
    ram_wdata = data_q;
    if (a_en) begin
      ram_re    = 1'b1;
      ram_we    = a_write && !a_prot;
      ram_addr  = a_addr;
      ram_wdata = a_in;
    end else begin
      unique case (state_q)
        FILL:    ram_we = 1'b1;
        COPY_RD: begin
          ram_re   = 1'b1;
          ram_addr = src_q;
        end
        COPY_WR: begin
          ram_we    = 1'b1;
          ram_wdata = copy_data;
        end
        default: ;
      endcase
    end
  end

  assign a_wp_err = wp_err_q;

  dp_ram #(
    .DATA_W   (DATA_W),
    .ADDR_W   (ADDR_W),
    .INIT_FILE(INIT_FILE)
  ) u_ram (
    .clk    (clk),
    .rst    (reset),
    .a_re   (ram_re),
    .a_we   (ram_we),
    .a_addr (ram_addr),
    .a_wdata(ram_wdata),
    .a_rdata(ram_rdata),
    .b_addr (b_addr),
    .b_rdata(b_out)
  );

endmodule

// File: tb/tb_cpu_memory_dma.sv
// Self-checking bench for cpu_memory_dma.
// Vector table for port A/B, scoreboard queue, engine command sequences.
module tb_cpu_memory_dma;
  import cpu_memory_pkg::*;

  logic        clk = 1'b0;
  logic        reset;
  logic        a_en, a_write;
  logic [11:0] a_addr;
  logic [7:0]  a_in, a_out;
  logic        a_wp_err;
  logic [11:0] b_addr;
  logic [7:0]  b_out;
  logic        cmd_valid, cmd_ready, cmd_op;
  logic [11:0] cmd_src, cmd_dst;
  logic [12:0] cmd_len;
  logic [7:0]  cmd_data;
  logic        busy, done;

  cpu_memory_dma #(
    .DATA_W(8), .ADDR_W(12), .PROTECT_TOP(512), .INIT_FILE("")
  ) dut (
    .clk(clk), .reset(reset),
    .a_en(a_en), .a_write(a_write), .a_addr(a_addr), .a_in(a_in),
    .a_out(a_out), .a_wp_err(a_wp_err),
    .b_addr(b_addr), .b_out(b_out),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
    .cmd_src(cmd_src), .cmd_dst(cmd_dst), .cmd_len(cmd_len),
    .cmd_data(cmd_data), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  int nvec = 0;
  int nmis = 0;
  logic [7:0] mdl [4096];
  logic [7:0] last_a_exp = 8'h00;

  typedef struct {
    string      name;
    bit         ca;
    logic [7:0] a;
    bit         ce;
    logic       e;
    bit         cb;
    logic [7:0] b;
  } sb_t;
  sb_t sb[$];

  typedef struct {
    logic       en;
    logic       wr;
    logic [11:0] addr;
    logic [7:0] din;
    logic [11:0] baddr;
    logic [7:0] ea;
    logic       ee;
    logic [7:0] eb;
  } vec_t;
  vec_t vt[10];

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    nvec++;
    if (act !== exp) begin
      nmis++;
      $display("FAIL %s: got %0h, want %0h", nm, act, exp);
    end
  endtask

  task automatic push(input string nm, input bit ca, input logic [7:0] a,
                      input bit ce, input logic e,
                      input bit cb, input logic [7:0] b);
    sb_t s;
    s.name = nm; s.ca = ca; s.a = a; s.ce = ce; s.e = e;
    s.cb = cb; s.b = b;
    if (ca) last_a_exp = a;
    sb.push_back(s);
  endtask

  // One clock; outputs are sampled 1ns after the edge.
  task automatic step();
    sb_t s;
    @(posedge clk);
    #1;
    if (sb.size() > 0) begin
      s = sb.pop_front();
      if (s.ca) chk({s.name, ".a_out"}, a_out, s.a);
      if (s.ce) chk({s.name, ".a_wp_err"}, a_wp_err, s.e);
      if (s.cb) chk({s.name, ".b_out"}, b_out, s.b);
    end
  endtask

  task automatic idle();
    a_en = 1'b0; a_write = 1'b0; a_addr = '0; a_in = '0;
    cmd_valid = 1'b0;
  endtask

  task automatic chk_region(input logic [11:0] start, input int len);
    logic [11:0] ad;
    for (int i = 0; i < len; i++) begin
      ad = start + 12'(i);
      b_addr = ad;
      push($sformatf("mem[%03h]", ad), 0, 8'h0, 0, 1'b0, 1, mdl[ad]);
      step();
    end
  endtask

  // Issue one command, optionally stall with CPU reads and poke a
  // second command while busy; check done latency and aftermath.
  task automatic run_cmd(input string nm, input logic op,
                         input logic [11:0] src, input logic [11:0] dst,
                         input logic [12:0] len, input logic [7:0] d,
                         input int exp_n, input int st_at,
                         input int st_len, input int poke_at);
    int n;
    bit seen;
    cmd_valid = 1'b1; cmd_op = op; cmd_src = src; cmd_dst = dst;
    cmd_len = len; cmd_data = d;
    step();
    cmd_valid = 1'b0;
    chk({nm, ".busy"}, busy, 1);
    chk({nm, ".cmd_ready"}, cmd_ready, 0);
    seen = 0;
    for (n = 1; n <= exp_n + 20; n++) begin
      if (done) begin
        seen = 1;
        break;
      end
      cmd_valid = (n == poke_at);
      if (n == poke_at) begin
        cmd_op = OP_FILL; cmd_dst = 12'h700; cmd_len = 13'd1;
        cmd_data = 8'hEE;
      end
      if (n >= st_at && n < st_at + st_len) begin
        a_en = 1'b1; a_write = 1'b0;
        a_addr = n[0] ? 12'h300 : 12'h200;
        push({nm, ".stall_rd"}, 1, mdl[a_addr], 1, 1'b0, 0, 8'h0);
      end else begin
        a_en = 1'b0;
      end
      step();
    end
    idle();
    if (!seen) begin
      nvec++; nmis++;
      $display("FAIL %s.done: timeout after %0d cycles, want %0d",
               nm, n, exp_n);
    end else begin
      chk({nm, ".done_cycle"}, n, exp_n);
      chk({nm, ".a_out_hold"}, a_out, last_a_exp);
      step();
      chk({nm, ".done_pulse"}, done, 0);
      chk({nm, ".ready_after"}, cmd_ready, 1);
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [11:0] ad;
    vt[0] = '{1, 1, 12'h300, 8'hAB, 12'h300, 8'h5A, 0, 8'h5A};
    vt[1] = '{1, 0, 12'h300, 8'h00, 12'h300, 8'hAB, 0, 8'hAB};
    vt[2] = '{1, 1, 12'h010, 8'h55, 12'h010, 8'h5A, 1, 8'h5A};
    vt[3] = '{1, 0, 12'h010, 8'h00, 12'h010, 8'h5A, 0, 8'h5A};
    vt[4] = '{0, 0, 12'h000, 8'h00, 12'h300, 8'h5A, 0, 8'hAB};
    vt[5] = '{1, 1, 12'h1FF, 8'h11, 12'h1FF, 8'h5A, 1, 8'h5A};
    vt[6] = '{1, 1, 12'h200, 8'h22, 12'h200, 8'h5A, 0, 8'h5A};
    vt[7] = '{1, 0, 12'h200, 8'h00, 12'h200, 8'h22, 0, 8'h22};
    vt[8] = '{1, 1, 12'h300, 8'hCD, 12'h300, 8'hAB, 0, 8'hAB};
    vt[9] = '{0, 0, 12'h000, 8'h00, 12'h300, 8'hAB, 0, 8'hCD};

    idle();
    cmd_op = 1'b0; cmd_src = '0; cmd_dst = '0; cmd_len = '0;
    cmd_data = '0; b_addr = '0;
    reset = 1'b1;
    repeat (3) step();
    chk("rst.a_out", a_out, 0);
    chk("rst.b_out", b_out, 0);
    chk("rst.a_wp_err", a_wp_err, 0);
    chk("rst.busy", busy, 0);
    chk("rst.done", done, 0);
    chk("rst.cmd_ready", cmd_ready, 1);
    reset = 1'b0;
    last_a_exp = 8'h00;
    step();

    run_cmd("fill_all", OP_FILL, 12'h0, 12'h0, 13'h1000, 8'h5A,
            4097, 0, 0, 0);
    for (int i = 0; i < 4096; i++) mdl[i] = 8'h5A;

    for (int i = 0; i < 10; i++) begin
      a_en = vt[i].en; a_write = vt[i].wr; a_addr = vt[i].addr;
      a_in = vt[i].din; b_addr = vt[i].baddr;
      push($sformatf("vec%0d", i), 1, vt[i].ea, 1, vt[i].ee,
           1, vt[i].eb);
      if (vt[i].en && vt[i].wr && vt[i].addr >= 12'h200)
        mdl[vt[i].addr] = vt[i].din;
      step();
    end
    idle();

    for (int i = 0; i < 16; i++) begin
      ad = 12'h200 + 12'(i);
      a_en = 1'b1; a_write = 1'b1; a_addr = ad;
      a_in = 8'(i * 7 + 3);
      push($sformatf("pat%0d", i), 1, mdl[ad], 1, 1'b0, 0, 8'h0);
      mdl[ad] = a_in;
      step();
    end
    idle();

    run_cmd("fill_f00", OP_FILL, 12'h0, 12'hF00, 13'd256, 8'h00,
            257, 0, 0, 3);
    for (int i = 0; i < 256; i++) mdl[12'hF00 + 12'(i)] = 8'h00;
    chk_region(12'hF00, 256);
    chk_region(12'h700, 1);

    run_cmd("fill_len0", OP_FILL, 12'h0, 12'h300, 13'd0, 8'h99,
            1, 0, 0, 0);
    chk_region(12'h300, 1);

    run_cmd("copy16", OP_COPY, 12'h200, 12'h400, 13'd16, 8'h00,
            38, 6, 5, 0);
    for (int i = 0; i < 16; i++)
      mdl[12'h400 + 12'(i)] = mdl[12'h200 + 12'(i)];
    chk_region(12'h400, 16);

    run_cmd("copy_ovl", OP_COPY, 12'h200, 12'h202, 13'd6, 8'h00,
            13, 0, 0, 0);
    for (int i = 0; i < 6; i++)
      mdl[12'h202 + 12'(i)] = mdl[12'h200 + 12'(i)];
    chk_region(12'h200, 8);

    run_cmd("fill_wrap", OP_FILL, 12'h0, 12'hFFE, 13'd4, 8'h77,
            5, 0, 0, 0);
    for (int i = 0; i < 4; i++) mdl[12'hFFE + 12'(i)] = 8'h77;
    chk_region(12'hFFD, 6);

    cmd_valid = 1'b1; cmd_op = OP_COPY; cmd_src = 12'h200;
    cmd_dst = 12'h600; cmd_len = 13'd32; cmd_data = 8'h00;
    step();
    cmd_valid = 1'b0;
    repeat (9) step();
    reset = 1'b1;
    step();
    chk("abort.busy", busy, 0);
    chk("abort.cmd_ready", cmd_ready, 1);
    chk("abort.done", done, 0);
    chk("abort.a_out", a_out, 0);
    reset = 1'b0;
    repeat (5) step();
    for (int i = 0; i < 5; i++)
      mdl[12'h600 + 12'(i)] = mdl[12'h200 + 12'(i)];
    chk_region(12'h600, 32);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
    $finish;
  end

endmodule
